// File: rtl/serial_word_assembler.sv
// Assembles a framed 1-bit serial stream into DATA_WIDTH-bit words with a one-cycle load strobe.
// Early restarts and mid-word stalls abort the partial word and pulse frame_err.
module serial_word_assembler #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sin_valid,
  input  logic                  sin_data,
  input  logic                  sin_start,
  output logic [DATA_WIDTH-1:0] word_out,
  output logic                  word_en,
  output logic                  frame_err,
  output logic                  busy,
  output logic [15:0]           word_cnt
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [TW-1:0]         to_q, to_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  en_q, en_d;
  logic                  fe_q, fe_d;

  logic [DATA_WIDTH-1:0] first_w;
  logic [DATA_WIDTH-1:0] shift_w;
  logic                  edge_bits_unused;

  // First bit sits at the end of the register that the shift direction pushes toward the far side.
  assign first_w = MSB_FIRST ? {{(DATA_WIDTH-1){1'b0}}, sin_data}
                             : {sin_data, {(DATA_WIDTH-1){1'b0}}};
  assign shift_w = MSB_FIRST ? {sr_q[DATA_WIDTH-2:0], sin_data}
                             : {sin_data, sr_q[DATA_WIDTH-1:1]};

  // The bit pushed out by the shift is never part of a valid word.
  assign edge_bits_unused = sr_q[DATA_WIDTH-1] ^ sr_q[0];

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    to_d    = to_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    fe_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sin_valid && sin_start) begin
          sr_d    = first_w;
          bit_d   = BW'(1);
          to_d    = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (sin_valid) begin
          to_d = '0;
          if (sin_start) begin
            fe_d  = 1'b1;
            sr_d  = first_w;
            bit_d = BW'(1);
          end else if (bit_q == BW'(DATA_WIDTH - 1)) begin
            word_d  = shift_w;
            en_d    = 1'b1;
            bit_d   = '0;
            state_d = S_IDLE;
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          end else begin
            sr_d  = shift_w;
            bit_d = bit_q + BW'(1);
          end
        end else if (to_q == TW'(TIMEOUT - 1)) begin
          fe_d    = 1'b1;
          to_d    = '0;
          bit_d   = '0;
          state_d = S_IDLE;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      bit_q   <= '0;
      to_q    <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      to_q    <= to_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      fe_q    <= fe_d;
    end
  end

  assign word_out  = word_q;
  assign word_en   = en_q;
  assign frame_err = fe_q;
  assign busy      = (state_q == S_SHIFT);
  assign word_cnt  = cnt_q;

endmodule
